// File: rtl/cache_pkg.sv
// Shared constants, FSM encodings and channel-format helpers for the
// set-associative cache level controller.
package cache_pkg;

    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_LINE_BYTES = 8;
    localparam int DEF_SETS       = 16;
    localparam int DEF_WAYS       = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LOOKUP    = 3'd1;
    localparam state_t ST_EVICT     = 3'd2;
    localparam state_t ST_FILL_REQ  = 3'd3;
    localparam state_t ST_FILL_WAIT = 3'd4;
    localparam state_t ST_RESPOND   = 3'd5;

    function automatic int push_w(input int addr_w, input int line_w);
        return 1 + addr_w + line_w;
    endfunction

    function automatic int pop_w(input int addr_w, input int line_w);
        return addr_w + line_w;
    endfunction

    // Rebuilds a byte address with zeroed offset bits from a tag and set index.
    function automatic logic [63:0] pack_line_addr(input logic [63:0] tag,
                                                   input logic [63:0] idx,
                                                   input int          idx_w,
                                                   input int          off_w);
        return ((tag << idx_w) | idx) << off_w;
    endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Per-set valid/dirty/tag storage and round-robin victim pointer with a
// combinational lookup port and a single synchronous update port.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int WAYS  = DEF_WAYS,
    parameter int TAG_W = 17,
    parameter int IDX_W = 4,
    parameter int WAY_W = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [IDX_W-1:0] lk_idx,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_hit,
    output logic [WAY_W-1:0] lk_hit_way,
    output logic [WAY_W-1:0] lk_victim,
    output logic             lk_victim_valid,
    output logic             lk_victim_dirty,
    output logic             lk_victim_from_ptr,
    output logic [TAG_W-1:0] lk_victim_tag,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [WAY_W-1:0] upd_way,
    input  logic             upd_valid,
    input  logic             upd_dirty,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic             ptr_adv
);

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAY_W-1:0] ptr_q   [SETS];

    logic             found_inv;
    logic [WAY_W-1:0] inv_way;

    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_way = '0;
        found_inv  = 1'b0;
        inv_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                lk_hit     = 1'b1;
                lk_hit_way = WAY_W'(w);
            end
        end
        // Descending scan leaves the lowest-index invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[lk_idx][w]) begin
                found_inv = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        lk_victim          = found_inv ? inv_way : ptr_q[lk_idx];
        lk_victim_from_ptr = !found_inv;
        lk_victim_valid    = valid_q[lk_idx][lk_victim];
        lk_victim_dirty    = dirty_q[lk_idx][lk_victim];
        lk_victim_tag      = tag_q[lk_idx][lk_victim];
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            if (upd_en) begin
                valid_q[upd_idx][upd_way] <= upd_valid;
                dirty_q[upd_idx][upd_way] <= upd_dirty;
            end
            if (ptr_adv) begin
                ptr_q[upd_idx] <= (ptr_q[upd_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                       : ptr_q[upd_idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (upd_en) begin
            tag_q[upd_idx][upd_way] <= upd_tag;
        end
    end

endmodule

// File: rtl/cache_level_ctrl.sv
// Write-back, write-allocate set-associative cache level: byte requests from
// the CPU side, dirty write-backs and refill requests pushed to the next level.
module cache_level_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int SETS       = DEF_SETS,
    parameter int WAYS       = DEF_WAYS,
    localparam int LINE_W    = 8 * LINE_BYTES,
    localparam int PUSH_W    = push_w(ADDR_W, LINE_W),
    localparam int POP_W     = pop_w(ADDR_W, LINE_W)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              resp_valid,
    output logic [7:0]        Dato_Salida,
    output logic              Hit,
    output logic              Desalojo,
    output logic              push_valid,
    input  logic              push_ready,
    output logic [PUSH_W-1:0] D_PUSH,
    input  logic [POP_W-1:0]  D_POP,
    input  logic              pop_valid
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              hit_q;
    logic              evict_q;
    logic [7:0]        rdata_q;
    logic [WAY_W-1:0]  victim_way_q;
    logic [TAG_W-1:0]  victim_tag_q;
    logic [LINE_W-1:0] victim_line_q;

    logic [LINE_W-1:0] data_mem [SETS][WAYS];

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [OFF_W+2:0]  bit_lo;
    logic [ADDR_W-1:0] req_laddr;
    logic [ADDR_W-1:0] victim_laddr;
    logic [63-ADDR_W:0] laddr_unused_a;
    logic [63-ADDR_W:0] laddr_unused_b;

    logic [ADDR_W-1:0] pop_laddr;
    logic [LINE_W-1:0] pop_line;
    logic              pop_match;
    logic [LINE_W-1:0] fill_line;

    logic             lk_hit;
    logic [WAY_W-1:0] lk_hit_way;
    logic [WAY_W-1:0] lk_victim;
    logic             lk_victim_valid;
    logic             lk_victim_dirty;
    logic             lk_victim_from_ptr;
    logic [TAG_W-1:0] lk_victim_tag;
    logic             upd_en;
    logic [WAY_W-1:0] upd_way;
    logic             upd_valid;
    logic             upd_dirty;
    logic [TAG_W-1:0] upd_tag;
    logic             ptr_adv;

    assign off    = addr_q[OFF_W-1:0];
    assign idx    = addr_q[OFF_W +: IDX_W];
    assign tag    = addr_q[ADDR_W-1 -: TAG_W];
    assign bit_lo = {off, 3'b000};

    assign {laddr_unused_a, req_laddr} =
        pack_line_addr(64'(tag), 64'(idx), IDX_W, OFF_W);
    assign {laddr_unused_b, victim_laddr} =
        pack_line_addr(64'(victim_tag_q), 64'(idx), IDX_W, OFF_W);

    assign {pop_laddr, pop_line} = D_POP;
    assign pop_match = (state_q == ST_FILL_WAIT) && pop_valid && (pop_laddr == req_laddr);

    always_comb begin
        fill_line = pop_line;
        if (we_q) begin
            fill_line[bit_lo +: 8] = wdata_q;
        end
    end

    cache_tag_array #(
        .SETS (SETS),
        .WAYS (WAYS),
        .TAG_W(TAG_W),
        .IDX_W(IDX_W),
        .WAY_W(WAY_W)
    ) u_tags (
        .CLK               (CLK),
        .Reset             (Reset),
        .lk_idx            (idx),
        .lk_tag            (tag),
        .lk_hit            (lk_hit),
        .lk_hit_way        (lk_hit_way),
        .lk_victim         (lk_victim),
        .lk_victim_valid   (lk_victim_valid),
        .lk_victim_dirty   (lk_victim_dirty),
        .lk_victim_from_ptr(lk_victim_from_ptr),
        .lk_victim_tag     (lk_victim_tag),
        .upd_en            (upd_en),
        .upd_idx           (idx),
        .upd_way           (upd_way),
        .upd_valid         (upd_valid),
        .upd_dirty         (upd_dirty),
        .upd_tag           (upd_tag),
        .ptr_adv           (ptr_adv)
    );

    always_comb begin
        upd_en    = 1'b0;
        upd_way   = victim_way_q;
        upd_valid = 1'b0;
        upd_dirty = 1'b0;
        upd_tag   = tag;
        ptr_adv   = 1'b0;
        case (state_q)
            ST_LOOKUP: begin
                if (lk_hit && we_q) begin
                    upd_en    = 1'b1;
                    upd_way   = lk_hit_way;
                    upd_valid = 1'b1;
                    upd_dirty = 1'b1;
                end
                ptr_adv = !lk_hit && lk_victim_from_ptr;
            end
            ST_EVICT: begin
                upd_en  = push_ready;
                upd_tag = victim_tag_q;
            end
            ST_FILL_WAIT: begin
                upd_en    = pop_match;
                upd_valid = 1'b1;
                upd_dirty = we_q;
            end
            default: ;
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign push_valid = (state_q == ST_EVICT) || (state_q == ST_FILL_REQ);

    always_comb begin
        D_PUSH = '0;
        if (state_q == ST_EVICT) begin
            D_PUSH = {1'b1, victim_laddr, victim_line_q};
        end else if (state_q == ST_FILL_REQ) begin
            D_PUSH = {1'b0, req_laddr, {LINE_W{1'b0}}};
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            resp_valid  <= 1'b0;
            Dato_Salida <= '0;
            Hit         <= 1'b0;
            Desalojo    <= 1'b0;
            evict_q     <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            resp_valid  <= 1'b0;
            Dato_Salida <= '0;
            Hit         <= 1'b0;
            Desalojo    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        evict_q <= 1'b0;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    hit_q <= lk_hit;
                    if (lk_hit) begin
                        rdata_q <= data_mem[idx][lk_hit_way][bit_lo +: 8];
                        state_q <= ST_RESPOND;
                    end else begin
                        victim_way_q  <= lk_victim;
                        victim_tag_q  <= lk_victim_tag;
                        victim_line_q <= data_mem[idx][lk_victim];
                        state_q <= (lk_victim_valid && lk_victim_dirty) ? ST_EVICT : ST_FILL_REQ;
                    end
                end
                ST_EVICT: begin
                    if (push_ready) begin
                        evict_q <= 1'b1;
                        state_q <= ST_FILL_REQ;
                    end
                end
                ST_FILL_REQ: begin
                    if (push_ready) begin
                        state_q <= ST_FILL_WAIT;
                    end
                end
                ST_FILL_WAIT: begin
                    if (pop_match) begin
                        rdata_q <= pop_line[bit_lo +: 8];
                        state_q <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    resp_valid  <= 1'b1;
                    Dato_Salida <= we_q ? 8'h00 : rdata_q;
                    Hit         <= hit_q;
                    Desalojo    <= evict_q;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            if (state_q == ST_LOOKUP && lk_hit && we_q) begin
                data_mem[idx][lk_hit_way][bit_lo +: 8] <= wdata_q;
            end
            if (pop_match) begin
                data_mem[idx][victim_way_q] <= fill_line;
            end
        end
    end

endmodule

// File: tb/tb_cache_level_ctrl.sv
// Directed bench for cache_level_ctrl: fills, hits, dirty eviction with
// push back-pressure, stray refills, mid-miss reset and held requests.
module tb_cache_level_ctrl;

    localparam int ADDR_W = 24;
    localparam int LINE_W = 64;
    localparam int PUSH_W = 1 + ADDR_W + LINE_W;
    localparam int POP_W  = ADDR_W + LINE_W;

    logic              CLK = 1'b0;
    logic              Reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [7:0]        req_wdata = '0;
    logic              resp_valid;
    logic [7:0]        Dato_Salida;
    logic              Hit;
    logic              Desalojo;
    logic              push_valid;
    logic              push_ready = 1'b0;
    logic [PUSH_W-1:0] D_PUSH;
    logic [POP_W-1:0]  D_POP = '0;
    logic              pop_valid = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    int resp_count = 0;

    cache_level_ctrl #(
        .ADDR_W    (24),
        .LINE_BYTES(8),
        .SETS      (16),
        .WAYS      (2)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .Dato_Salida(Dato_Salida),
        .Hit        (Hit),
        .Desalojo   (Desalojo),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .D_PUSH     (D_PUSH),
        .D_POP      (D_POP),
        .pop_valid  (pop_valid)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (resp_valid === 1'b1) resp_count++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkp(input string tag, input logic [PUSH_W-1:0] obs, input logic [PUSH_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic [7:0] d, input logic h, input logic e);
        chk1({tag, "_valid"}, resp_valid, 1'b1);
        chk8({tag, "_data"}, Dato_Salida, d);
        chk1({tag, "_hit"}, Hit, h);
        chk1({tag, "_evict"}, Desalojo, e);
    endtask

    task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic push_ack();
        push_ready = 1'b1;
        tick();
        push_ready = 1'b0;
    endtask

    task automatic pop(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] l);
        D_POP     = {a, l};
        pop_valid = 1'b1;
        tick();
        pop_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        Reset = 1'b1;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_push_valid", push_valid, 1'b0);
        chkp("rst_d_push", D_PUSH, '0);
        chk8("rst_dato", Dato_Salida, 8'h00);
        chk1("rst_hit", Hit, 1'b0);
        chk1("rst_desalojo", Desalojo, 1'b0);

        // Cold miss on 0x13, then hit on 0x15 in the same line.
        issue(1'b0, 24'h000013, 8'h00);
        tick();
        req_valid = 1'b0;
        chk1("t1_busy", req_ready, 1'b0);
        tick();
        chk1("t1_push_valid", push_valid, 1'b1);
        chkp("t1_fill_req", D_PUSH, {1'b0, 24'h000010, 64'h0});
        push_ack();
        chk1("t1_push_done", push_valid, 1'b0);
        pop(24'h000010, 64'h8877665544332211);
        chk1("t1_no_resp_yet", resp_valid, 1'b0);
        tick();
        chk_resp("t1_miss", 8'h44, 1'b0, 1'b0);

        issue(1'b0, 24'h000015, 8'h00);
        tick();
        req_valid = 1'b0;
        chk1("t1h_c1_resp", resp_valid, 1'b0);
        chk1("t1h_c1_push", push_valid, 1'b0);
        tick();
        chk1("t1h_c2_resp", resp_valid, 1'b0);
        chk1("t1h_c2_push", push_valid, 1'b0);
        tick();
        chk_resp("t1_hit", 8'h66, 1'b1, 1'b0);

        // Write hit dirties way0, fill way1, then conflict evicts way0.
        issue(1'b1, 24'h000011, 8'hAB);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk_resp("t2_wr_hit", 8'h00, 1'b1, 1'b0);

        issue(1'b0, 24'h000090, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        chkp("t2_fill90_req", D_PUSH, {1'b0, 24'h000090, 64'h0});
        push_ack();
        pop(24'h000090, 64'h1122334455667788);
        tick();
        chk_resp("t2_fill90", 8'h88, 1'b0, 1'b0);

        issue(1'b0, 24'h000110, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1("t3_push_valid", push_valid, 1'b1);
            chkp("t3_evict_push", D_PUSH, {1'b1, 24'h000010, 64'h887766554433AB11});
            chk1("t3_no_resp", resp_valid, 1'b0);
            chk1("t3_not_ready", req_ready, 1'b0);
            tick();
        end
        push_ack();
        chk1("t2_fill110_valid", push_valid, 1'b1);
        chkp("t2_fill110_req", D_PUSH, {1'b0, 24'h000110, 64'h0});
        push_ack();

        // Stray refill with the wrong line address must be dropped.
        pop(24'h000050, 64'hDEADBEEFCAFEF00D);
        chk1("t4_stray_resp", resp_valid, 1'b0);
        chk1("t4_stray_ready", req_ready, 1'b0);
        tick();
        chk1("t4_stray_resp2", resp_valid, 1'b0);
        pop(24'h000110, 64'hF0E0D0C0B0A09080);
        chk1("t4_respond_entered", resp_valid, 1'b0);
        tick();
        chk_resp("t2_evict_resp", 8'h80, 1'b0, 1'b1);

        // Reset in FILL_WAIT aborts the miss silently.
        issue(1'b0, 24'h000013, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        chkp("t5_fill_req", D_PUSH, {1'b0, 24'h000010, 64'h0});
        push_ack();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chk1("t5_ready", req_ready, 1'b1);
        chk1("t5_push", push_valid, 1'b0);
        chk1("t5_resp", resp_valid, 1'b0);
        pop(24'h000010, 64'h1111111111111111);
        chk1("t5_late_pop_resp", resp_valid, 1'b0);
        tick();
        chk1("t5_late_pop_resp2", resp_valid, 1'b0);

        issue(1'b0, 24'h000013, 8'h00);
        tick();
        req_valid = 1'b0;
        tick();
        chkp("t5_refill_req", D_PUSH, {1'b0, 24'h000010, 64'h0});
        push_ack();
        pop(24'h000010, 64'h0102030405060708);
        tick();
        chk_resp("t5_after_rst", 8'h05, 1'b0, 1'b0);

        // req_valid held through a miss: second accept only after IDLE.
        issue(1'b0, 24'h000210, 8'h00);
        tick();
        chk1("t6_busy_lookup", req_ready, 1'b0);
        tick();
        chk1("t6_busy_fill", req_ready, 1'b0);
        chkp("t6_fill_req", D_PUSH, {1'b0, 24'h000210, 64'h0});
        push_ack();
        pop(24'h000210, 64'hAAAABBBBCCCCDDDD);
        chk1("t6_busy_respond", req_ready, 1'b0);
        tick();
        chk_resp("t6_first", 8'hDD, 1'b0, 1'b0);
        chk1("t6_ready_again", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk1("t6_second_accepted", req_ready, 1'b0);
        tick();
        tick();
        chk_resp("t6_second", 8'hDD, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk32("resp_count", resp_count, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
